task_dispatcher: RTL

TASK_DISPATCHER -- requirements
Module: task_dispatcher

---
 rtl/task_pkg.sv | 36 +++
 rtl/task_fifo.sv | 56 +++++
 rtl/task_dispatcher.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/task_pkg.sv
// Shared types and constants for the task dispatcher: FSM states, opcodes,
// error codes and the task-number decoder.
package task_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  localparam logic [6:0] OP_CODE_10 = 7'h03;
  localparam logic [6:0] OP_CODE_20 = 7'h01;
  localparam logic [6:0] OP_CODE_30 = 7'h05;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [6:0] GRANT_DT_DEF = 7'h04;

  typedef struct packed {
    logic       ok;
    logic [6:0] op;
  } decode_t;

  // Only the low byte of a task number selects the MHP opcode.
  function automatic decode_t decode_task(input logic [7:0] code);
    decode_t d;
    d.ok = 1'b1;
    d.op = '0;
    case (code)
      8'h10:   d.op = OP_CODE_10;
      8'h20:   d.op = OP_CODE_20;
      8'h30:   d.op = OP_CODE_30;
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/task_fifo.sv
// Task queue: first-word-fall-through FIFO with an exact occupancy count.
module task_fifo
  import task_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push is refused whenever full, even if a pop frees a slot this cycle.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// Pops queued tasks, issues them as MHP requests and waits for a grant,
// resending on timeout a bounded number of times before reporting failure.
module task_dispatcher
  import task_pkg::*;
#(
  parameter int         TASK_W    = 16,
  parameter int         ADDR_W    = 16,
  parameter int         DEPTH     = 4,
  parameter int         TIMEOUT   = 1024,
  parameter int         MAX_RETRY = 2,
  parameter logic [6:0] GRANT_DT  = GRANT_DT_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_task_valid,
  input  logic [TASK_W-1:0]      i_task_nbr,
  output logic                   o_task_ready,
  output logic                   o_send,
  output logic                   o_enable,
  output logic [7:0]             o_dtype,
  input  logic                   i_done,
  input  logic                   i_rx_valid,
  input  logic [6:0]             i_rx_dtype,
  input  logic [ADDR_W-1:0]      i_rx_dst,
  input  logic [ADDR_W-1:0]      i_rx_src,
  output logic                   o_grant,
  output logic                   o_fail,
  output logic [1:0]             o_err,
  output logic [TASK_W-1:0]      o_task,
  output logic [ADDR_W-1:0]      o_dst_addr,
  output logic [ADDR_W-1:0]      o_src_addr,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_link
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  state_t            state;
  logic [TASK_W-1:0] cur_task;
  logic [TASK_W-1:0] head;
  logic [TMR_W-1:0]  timer;
  logic [RTY_W-1:0]  retries;
  logic              full;
  logic              empty;
  logic              pop;
  decode_t           head_dec;

  // Holding off the pop while a pulse is out keeps back-to-back results apart.
  assign pop          = (state == IDLE) && !empty && !o_grant && !o_fail;
  assign head_dec     = decode_task(head[7:0]);
  assign o_task_ready = !full;
  assign o_link       = o_enable;

  task_fifo #(
    .WIDTH(TASK_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (i_clk),
    .rst    (i_rst),
    .push   (i_task_valid),
    .pop    (pop),
    .wr_data(i_task_nbr),
    .rd_data(head),
    .full   (full),
    .empty  (empty),
    .level  (o_level)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cur_task   <= '0;
      timer      <= '0;
      retries    <= '0;
      o_send     <= 1'b0;
      o_enable   <= 1'b0;
      o_dtype    <= '0;
      o_grant    <= 1'b0;
      o_fail     <= 1'b0;
      o_err      <= ERR_NONE;
      o_task     <= '0;
      o_dst_addr <= '0;
      o_src_addr <= '0;
      o_busy     <= 1'b0;
    end else begin
      o_grant <= 1'b0;
      o_fail  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur_task <= head;
            timer    <= '0;
            retries  <= '0;
            if (head_dec.ok) begin
              o_send   <= 1'b1;
              o_enable <= 1'b1;
              o_busy   <= 1'b1;
              o_dtype  <= {1'b1, head_dec.op};
              state    <= SEND;
            end else begin
              o_fail <= 1'b1;
              o_err  <= ERR_BAD;
              o_task <= head;
            end
          end
        end
        SEND: begin
          if (i_done) begin
            o_send <= 1'b0;
            timer  <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + TMR_W'(1);
          // A grant takes priority over a timeout landing in the same cycle.
          if (i_rx_valid && (i_rx_dtype == GRANT_DT)) begin
            o_dst_addr <= i_rx_dst;
            o_src_addr <= i_rx_src;
            o_grant    <= 1'b1;
            o_err      <= ERR_NONE;
            o_task     <= cur_task;
            o_enable   <= 1'b0;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            if (retries < RTY_W'(MAX_RETRY)) begin
              retries <= retries + RTY_W'(1);
              o_send  <= 1'b1;
              state   <= SEND;
            end else begin
              o_fail   <= 1'b1;
              o_err    <= ERR_TIMEOUT;
              o_task   <= cur_task;
              o_enable <= 1'b0;
              o_busy   <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
